// File: rtl/phase_scheduler.sv
// Game-flow controller: title -> menu -> dodge -> game-over, with dodge timer, wave count and hit rate limiting.
// Optional pause key in DODGE is compiled in with PHASE_SCHED_PAUSE_EN.
module phase_scheduler #(
  parameter int unsigned DODGE_FRAMES  = 600,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter logic [7:0]  KEY_START     = 8'h5A,
  parameter logic [7:0]  KEY_CONFIRM   = 8'h1A,
  parameter int unsigned MAX_WAVE      = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] keycode,
  input  logic        frame_tick,
  input  logic        collision,
  input  logic [1:0]  hp,
  output logic [1:0]  state,
  output logic [2:0]  wave,
  output logic [9:0]  time_left,
  output logic        dodge_start,
  output logic        hit,
  output logic        paused
);

  typedef enum logic [1:0] {
    S_TITLE = 2'b00,
    S_MENU  = 2'b10,
    S_DODGE = 2'b01,
    S_OVER  = 2'b11
  } phase_t;

  localparam logic [9:0] L_DODGE  = 10'(DODGE_FRAMES);
  localparam logic [7:0] L_INVULN = 8'(INVULN_FRAMES);
  localparam logic [2:0] L_MAXW   = 3'(MAX_WAVE);

  phase_t      r_state, w_state;
  logic [15:0] r_kc_q;
  logic [2:0]  r_wave, w_wave;
  logic [9:0]  r_time_left, w_time_left;
  logic [7:0]  r_invuln, w_invuln;
  logic        r_dodge_start, w_dodge_start;
  logic        r_hit, w_hit;
  logic        r_paused, w_paused;
  logic        w_press, w_start_key, w_confirm_key, w_pause_key, w_hold, w_tick;

  assign w_press       = (keycode != r_kc_q) && (keycode[15:8] != 8'hF0);
  assign w_start_key   = w_press && (keycode[7:0] == KEY_START);
  assign w_confirm_key = w_press && (keycode[7:0] == KEY_CONFIRM);

`ifdef PHASE_SCHED_PAUSE_EN
  assign w_pause_key = w_press && (keycode[7:0] == 8'h4D);
  assign w_hold      = r_paused;
`else
  assign w_pause_key = 1'b0;
  assign w_hold      = 1'b0;
`endif

  // A paused dodge phase neither meters frames nor accepts hits.
  assign w_tick = frame_tick && !w_hold;

  // Next-state and next-output decode.
  always_comb begin
    w_state       = r_state;
    w_wave        = r_wave;
    w_time_left   = r_time_left;
    w_invuln      = r_invuln;
    w_dodge_start = 1'b0;
    w_hit         = 1'b0;
    w_paused      = r_paused;
    case (r_state)
      S_TITLE: begin
        if (w_start_key) begin
          w_state = S_MENU;
          w_wave  = 3'd0;
        end else begin
          w_state = S_TITLE;
        end
      end
      S_MENU: begin
        if (w_confirm_key) begin
          w_state       = S_DODGE;
          w_time_left   = L_DODGE;
          w_invuln      = 8'd0;
          w_dodge_start = 1'b1;
        end else begin
          w_state = S_MENU;
        end
      end
      S_DODGE: begin
        if (hp == 2'b00) begin
          w_state  = S_OVER;
          w_paused = 1'b0;
        end else if (w_tick && (r_time_left == 10'd1)) begin
          w_state     = S_MENU;
          w_time_left = 10'd0;
          w_wave      = (r_wave >= L_MAXW) ? L_MAXW : r_wave + 3'd1;
          w_paused    = 1'b0;
        end else begin
          if (w_tick) begin
            w_time_left = (r_time_left != 10'd0) ? r_time_left - 10'd1 : 10'd0;
            w_invuln    = (r_invuln != 8'd0) ? r_invuln - 8'd1 : 8'd0;
          end else begin
            w_invuln = r_invuln;
          end
          if (w_pause_key) begin
            w_paused = !r_paused;
          end else begin
            w_paused = r_paused;
          end
        end
        // The hit is still issued when this same edge leaves DODGE.
        if (collision && (r_invuln == 8'd0) && !w_hold) begin
          w_hit    = 1'b1;
          w_invuln = L_INVULN;
        end else begin
          w_hit = 1'b0;
        end
      end
      S_OVER: begin
        if (w_start_key) begin
          w_state = S_TITLE;
          w_wave  = 3'd0;
        end else begin
          w_state = S_OVER;
        end
      end
      default: begin
        w_state = S_TITLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_TITLE;
      r_kc_q        <= 16'h0000;
      r_wave        <= 3'd0;
      r_time_left   <= 10'd0;
      r_invuln      <= 8'd0;
      r_dodge_start <= 1'b0;
      r_hit         <= 1'b0;
      r_paused      <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_kc_q        <= keycode;
      r_wave        <= w_wave;
      r_time_left   <= w_time_left;
      r_invuln      <= w_invuln;
      r_dodge_start <= w_dodge_start;
      r_hit         <= w_hit;
      r_paused      <= w_paused;
    end
  end

  assign state       = r_state;
  assign wave        = r_wave;
  assign time_left   = r_time_left;
  assign dodge_start = r_dodge_start;
  assign hit         = r_hit;
  assign paused      = r_paused;

endmodule

// File: tb/tb_phase_scheduler.sv
// Scoreboard bench for phase_scheduler: a phase-level reference model pushes expected outputs per cycle,
// a monitor pops and compares them. Honours PHASE_SCHED_PAUSE_EN like the design.
module tb_phase_scheduler;

  localparam int DF = 4;
  localparam int IF = 2;
  localparam int MW = 3;
`ifdef PHASE_SCHED_PAUSE_EN
  localparam bit PAUSE = 1'b1;
`else
  localparam bit PAUSE = 1'b0;
`endif

  localparam int PH_TITLE = 0;
  localparam int PH_MENU  = 1;
  localparam int PH_DODGE = 2;
  localparam int PH_OVER  = 3;

  typedef struct packed {
    logic [1:0] st;
    logic [2:0] wv;
    logic [9:0] tl;
    logic       ds;
    logic       ht;
    logic       pz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keycode = 16'h0000;
  logic        frame_tick = 1'b0;
  logic        collision = 1'b0;
  logic [1:0]  hp = 2'b11;
  logic [1:0]  state;
  logic [2:0]  wave;
  logic [9:0]  time_left;
  logic        dodge_start, hit, paused;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  int          m_phase, m_wave, m_tl, m_inv;
  bit          m_pz;
  logic [15:0] m_kcq;

  phase_scheduler #(
    .DODGE_FRAMES(DF), .INVULN_FRAMES(IF), .KEY_START(8'h5A), .KEY_CONFIRM(8'h1A), .MAX_WAVE(MW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keycode(keycode), .frame_tick(frame_tick), .collision(collision),
    .hp(hp), .state(state), .wave(wave), .time_left(time_left), .dodge_start(dodge_start),
    .hit(hit), .paused(paused)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] phase_bus(input int p);
    case (p)
      PH_TITLE: return 2'b00;
      PH_MENU:  return 2'b10;
      PH_DODGE: return 2'b01;
      default:  return 2'b11;
    endcase
  endfunction

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_TITLE; m_wave = 0; m_tl = 0; m_inv = 0; m_pz = 1'b0; m_kcq = 16'h0000;
  endtask

  // Reference model: one clock edge worth of game rules, result queued for the monitor.
  task automatic model_step(input logic [15:0] kc, input bit ft, input bit col, input logic [1:0] h);
    bit   pr, frozen, hit_now, ds;
    exp_t e;
    pr      = (kc != m_kcq) && (kc[15:8] != 8'hF0);
    m_kcq   = kc;
    frozen  = m_pz;
    ds      = 1'b0;
    hit_now = (m_phase == PH_DODGE) && col && (m_inv == 0) && !frozen;
    case (m_phase)
      PH_TITLE: if (pr && kc[7:0] == 8'h5A) begin m_phase = PH_MENU; m_wave = 0; end
      PH_MENU:  if (pr && kc[7:0] == 8'h1A) begin m_phase = PH_DODGE; m_tl = DF; m_inv = 0; ds = 1'b1; end
      PH_DODGE: begin
        if (h == 2'd0) begin
          m_phase = PH_OVER; m_pz = 1'b0;
        end else if (ft && !frozen && m_tl == 1) begin
          m_phase = PH_MENU; m_tl = 0; m_pz = 1'b0;
          if (m_wave < MW) m_wave++;
        end else begin
          if (ft && !frozen) begin
            if (m_tl > 0) m_tl--;
            if (m_inv > 0) m_inv--;
          end
          if (PAUSE && pr && kc[7:0] == 8'h4D) m_pz = !m_pz;
        end
      end
      default:  if (pr && kc[7:0] == 8'h5A) begin m_phase = PH_TITLE; m_wave = 0; end
    endcase
    if (hit_now) m_inv = IF;
    e.st = phase_bus(m_phase);
    e.wv = 3'(m_wave);
    e.tl = 10'(m_tl);
    e.ds = ds;
    e.ht = hit_now;
    e.pz = m_pz;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [15:0] kc, input bit ft, input bit col, input logic [1:0] h);
    @(negedge clk);
    rst_n = 1'b1; keycode = kc; frame_tick = ft; collision = col; hp = h;
    model_step(kc, ft, col, h);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_wave"}, int'(wave), 0);
    check({tag, "_time_left"}, int'(time_left), 0);
    check({tag, "_dodge_start"}, int'(dodge_start), 0);
    check({tag, "_hit"}, int'(hit), 0);
    check({tag, "_paused"}, int'(paused), 0);
  endtask

  // Asynchronous reset between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    @(posedge clk);
  endtask

  // Monitor: compare DUT outputs against the queued expectation after every edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("state", int'(state), int'(mon_e.st));
      check("wave", int'(wave), int'(mon_e.wv));
      check("time_left", int'(time_left), int'(mon_e.tl));
      check("dodge_start", int'(dodge_start), int'(mon_e.ds));
      check("hit", int'(hit), int'(mon_e.ht));
      check("paused", int'(paused), int'(mon_e.pz));
    end
  end

  logic [15:0] kpool [8];
  logic [15:0] kc_cur;
  logic [1:0]  hp_r;

  initial begin
    kpool[0] = 16'h005A; kpool[1] = 16'hF05A; kpool[2] = 16'h001A; kpool[3] = 16'hF01A;
    kpool[4] = 16'h004D; kpool[5] = 16'hF04D; kpool[6] = 16'h0012; kpool[7] = 16'h1A5A;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");

    // Directed walk through the main flow.
    step(16'h005A, 1'b0, 1'b0, 2'd3);
    step(16'hF05A, 1'b0, 1'b0, 2'd3);
    step(16'h001A, 1'b0, 1'b1, 2'd3);
    for (int i = 0; i < 8; i++) step(16'h001A, (i % 2 == 1), 1'b1, 2'd3);
    step(16'h001A, 1'b0, 1'b0, 2'd3);
    step(16'hF01A, 1'b0, 1'b0, 2'd3);
    step(16'h001A, 1'b0, 1'b0, 2'd3);
    for (int i = 0; i < 3; i++) step(16'h001A, 1'b1, 1'b0, 2'd3);
    step(16'h001A, 1'b1, 1'b0, 2'd0);
    step(16'h005A, 1'b0, 1'b0, 2'd3);
    step(16'hF05A, 1'b0, 1'b0, 2'd3);
    step(16'h005A, 1'b0, 1'b0, 2'd3);
    step(16'h001A, 1'b0, 1'b0, 2'd3);
    step(16'h004D, 1'b0, 1'b0, 2'd3);
    step(16'h004D, 1'b1, 1'b1, 2'd3);
    step(16'hF04D, 1'b1, 1'b1, 2'd3);
    step(16'h004D, 1'b0, 1'b0, 2'd3);
    step(16'h004D, 1'b1, 1'b1, 2'd3);
    async_reset();

    // Randomized play.
    kc_cur = 16'h0000;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        async_reset();
      end else begin
        if ($urandom_range(0, 9) >= 4) kc_cur = kpool[$urandom_range(0, 7)];
        hp_r = ($urandom_range(0, 59) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
        step(kc_cur, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), hp_r);
      end
    end
    repeat (3) @(posedge clk);
    #2 check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_scheduler.md
# phase_scheduler

Game-flow controller that owns the 2-bit `state` bus consumed by the border, player and bullet sprite generators, replacing the constant state tie-off in the top level. It sequences title → menu → dodge → game-over from PS/2 keycodes, frame ticks and player HP. It also meters the dodge phase with a frame timer, raises the wave number, and rate-limits collision hits with an invulnerability window.

## Interface
Parameters:
- `DODGE_FRAMES`, 600, dodge-phase length in frames (≤1023)
- `INVULN_FRAMES`, 60, frames of hit immunity after a counted hit (≤255)
- `KEY_START`, 8'h5A, scan code that starts or restarts (Enter)
- `KEY_CONFIRM`, 8'h1A, scan code that begins a dodge phase from the menu (Z)
- `MAX_WAVE`, 7, wave counter saturation value

Ports:
- `clk` in 1: 100 MHz system clock
- `rst_n` in 1: asynchronous, active-low reset
- `keycode` in 16: PS/2 keyboard module output; [7:0] last scan code, [15:8] previous byte (8'hF0 = break)
- `frame_tick` in 1: one-`clk` pulse per video frame
- `collision` in 1: player/bullet overlap, level-sensitive
- `hp` in 2: player HP
- `state` out 2: 00 TITLE, 10 MENU, 01 DODGE, 11 OVER
- `wave` out 3: current wave, 0..MAX_WAVE
- `time_left` out 10: remaining dodge frames
- `dodge_start` out 1: one-cycle pulse on entry to DODGE
- `hit` out 1: one-cycle HP-decrement request to the player
- `paused` out 1: pause flag (0 when pause is compiled out)

## Operation
- Key event: `keycode` is registered into `kc_q` every cycle. `press` = (`keycode` != `kc_q`) && (`keycode[15:8]` != 8'hF0). Typematic repeats of an identical code produce no event. Break codes never produce an event.
- TITLE: `press` of KEY_START → MENU. `wave` is cleared to 0.
- MENU: `press` of KEY_CONFIRM → DODGE. `time_left` loads DODGE_FRAMES, `dodge_start` pulses, and `invuln` clears.
- DODGE, evaluated in priority order:
  1. `hp`==0 → OVER.
  2. On `frame_tick` with `time_left`==1 → MENU, `time_left` goes to 0, and `wave` increments, saturating at MAX_WAVE.
  3. On any other `frame_tick`, `time_left` decrements, and `invuln` decrements if nonzero.
- Hit logic, active in DODGE only: when `collision` && `invuln`==0, `hit` pulses for one cycle and `invuln` loads INVULN_FRAMES. The hit fires even if the state leaves DODGE on the same edge. Collision while `invuln`≠0 is ignored.
- OVER: `press` of KEY_START → TITLE. All other keys are ignored.
- Keys not listed for the current state are ignored. `hp` is ignored outside DODGE.

## Timing
- All outputs are registered. The reset value of every output and internal register is 0: `state`=00 (TITLE), `wave`=0, `time_left`=0, `invuln`=0, `kc_q`=0, and `dodge_start`=`hit`=`paused`=0.
- Latency: a `keycode` change at edge N is seen as `press` before edge N+1, and `state`/pulses update at edge N+1.
- `frame_tick` to `time_left` update: 1 cycle.
- `hp` reaching 0 to `state`=OVER: 1 cycle, independent of `frame_tick`.
- Simultaneous `hp`==0 and timer expiry: OVER wins, and `wave` does not increment.
- `dodge_start` and `hit` are never asserted for more than one consecutive cycle.
- Reset asserted mid-phase forces all outputs to their reset values immediately (asynchronous). Operation resumes from TITLE on the first edge after deassertion.
- `keycode` equal to `kc_q` at reset release produces no event.

## Configuration
- `PHASE_SCHED_PAUSE_EN` defined: in DODGE, a `press` of scan code 8'h4D (P) toggles `paused`.
  - While `paused`=1, `frame_tick` is ignored for `time_left` and `invuln`, and `hit` is suppressed.
  - The `hp`==0 → OVER transition still applies.
  - `paused` clears on any exit from DODGE.
- Macro undefined: `paused` is tied to 0, and 8'h4D is an ordinary ignored key.

## Test plan
- Reset, then `keycode`=16'h005A → `state`=10 after 1 cycle. Then 16'hF05A → `state` stays 10.
- DODGE_FRAMES=4: from MENU, `keycode`=16'h001A → `state`=01, `dodge_start` high for one cycle, `time_left`=4. Four `frame_tick`s → `time_left` reads 3,2,1, then `state`=10 with `wave`=1.
- INVULN_FRAMES=2: `collision` held high in DODGE → `hit` pulses at the first cycle, then again only after 2 further `frame_tick`s.
- In DODGE, drive `hp`=0 on the same cycle as the final `frame_tick` → `state`=11 and `wave` unchanged. Then `keycode`=16'h005A → `state`=00 and `wave`=0.
- Hold `keycode`=16'h001A constant across the MENU→DODGE→MENU cycle → no second DODGE entry. Also pulse `rst_n` low mid-DODGE → all outputs are 0 immediately.
- With PHASE_SCHED_PAUSE_EN: in DODGE, `keycode`=16'h004D → `paused`=1. `frame_tick`s then leave `time_left` frozen and `collision` gives no `hit`. A second 8'h4D press (keycode reissued as 16'hF04D, then 16'h004D) → `paused`=0.
